// File: rtl/gs232c_jhr_pkg.sv
// Shared sizing, shift and fold helpers for the gs232c indirect-jump path history.
// Helpers work on a fixed wide vector so any HW up to MaxHw can use them.
package gs232c_jhr_pkg;

  localparam int unsigned MaxHw = 512;

  function automatic int unsigned calc_hw(input int unsigned hist_n, input int unsigned tgt_bits);
    return hist_n * tgt_bits;
  endfunction

  function automatic int unsigned calc_sw(input int unsigned max_spec);
    return $clog2(max_spec + 1);
  endfunction

  // Oldest jump drops off the top; new target bits enter at the bottom.
  function automatic logic [MaxHw-1:0] shift_hist(input logic [MaxHw-1:0] h,
                                                  input logic [31:0]      t,
                                                  input int unsigned      hw,
                                                  input int unsigned      tgt_bits);
    logic [31:0]      tbits;
    logic [MaxHw-1:0] mask;
    tbits = (t >> 2) & ((32'd1 << tgt_bits) - 32'd1);
    mask  = (hw >= MaxHw) ? '1 : ((MaxHw'(1) << hw) - MaxHw'(1));
    return ((h << tgt_bits) | MaxHw'(tbits)) & mask;
  endfunction

  // Bit i lands in fold bit i%fw, which XORs fw-wide slices with the top slice zero-padded.
  function automatic logic [MaxHw-1:0] fold_hist(input logic [MaxHw-1:0] h,
                                                 input int unsigned      hw,
                                                 input int unsigned      fw);
    logic [MaxHw-1:0] f;
    f = '0;
    for (int unsigned i = 0; i < MaxHw; i++) begin
      if (i < hw) f[i % fw] = f[i % fw] ^ h[i];
    end
    return f;
  endfunction

endpackage

// File: rtl/jhr_stage.sv
// One pipeline stage of path history: load (repair), shift on jrop, or hold.
// The optional last-target register tracks target[31:2] of the most recent jump.
module jhr_stage import gs232c_jhr_pkg::*; #(
  parameter int unsigned TGT_BITS = 8,
  parameter int unsigned HW       = 64,
  parameter bit          HAS_LAST = 1'b1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load,
  input  logic [HW-1:0] load_hist,
  input  logic [29:0]   load_last,
  input  logic          jrop,
  input  logic [31:0]   target,
  output logic [HW-1:0] hist,
  output logic [29:0]   last,
  output logic [HW-1:0] hist_next,
  output logic [29:0]   last_next
);

  logic [MaxHw-1:0] shifted;
  logic             unused_shift_hi;

  always_comb begin
    shifted   = shift_hist(MaxHw'(hist), target, HW, TGT_BITS);
    hist_next = jrop ? shifted[HW-1:0] : hist;
  end

  assign unused_shift_hi = ^shifted[MaxHw-1:HW];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hist <= '0;
    end else if (load) begin
      hist <= load_hist;
    end else begin
      hist <= hist_next;
    end
  end

  if (HAS_LAST) begin : g_last
    assign last_next = jrop ? target[31:2] : last;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        last <= '0;
      end else if (load) begin
        last <= load_last;
      end else begin
        last <= last_next;
      end
    end
  end else begin : g_no_last
    logic unused_load_last;
    assign unused_load_last = ^load_last;
    assign last             = '0;
    assign last_next        = '0;
  end

endmodule

// File: rtl/gs232c_jhr_ckpt.sv
// Indirect-jump path history with per-stage checkpoints, cancel repair, folded output
// and a speculative-depth counter.
module gs232c_jhr_ckpt import gs232c_jhr_pkg::*; #(
  parameter int unsigned  TGT_BITS = 8,
  parameter int unsigned  HIST_N   = 8,
  parameter int unsigned  FOLD_W   = 10,
  parameter int unsigned  MAX_SPEC = 7,
  localparam int unsigned HW       = calc_hw(HIST_N, TGT_BITS),
  localparam int unsigned SW       = calc_sw(MAX_SPEC)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pc_go,
  input  logic              bt_jrop,
  input  logic [31:0]       bt_target,
  input  logic              pr_cancel,
  input  logic              pr_jrop,
  input  logic [31:0]       pr_target,
  input  logic              br_cancel,
  input  logic              br_jrop,
  input  logic [31:0]       br_target,
  input  logic              wb_cancel,
  input  logic              wb_jrop,
  input  logic [31:0]       wb_target,
  output logic [HW-1:0]     hr_path_bt,
  output logic [HW-1:0]     hr_path_br,
  output logic [FOLD_W-1:0] hr_fold_bt,
  output logic [29:0]       hr_last_pr,
  output logic [29:0]       hr_last_br,
  output logic [SW-1:0]     hr_spec_cnt
);

  logic          push;
  logic          any_cancel;
  logic [HW-1:0] pr_next, br_next, wb_next;
  logic [29:0]   br_last_next, wb_last_next;
  logic [HW-1:0] bt_repair, pr_repair;
  logic [29:0]   pr_repair_last;

  logic [HW-1:0] unused_bt_next, unused_pr_hist, unused_wb_hist;
  logic [29:0]   unused_bt_last, unused_bt_last_next, unused_pr_last_next, unused_wb_last;

  assign push       = bt_jrop && pc_go;
  assign any_cancel = wb_cancel || br_cancel || pr_cancel;

  // Oldest cancelling stage wins; each repair includes that stage's same-cycle jrop.
  always_comb begin
    bt_repair      = pr_next;
    pr_repair      = br_next;
    pr_repair_last = br_last_next;
    if (wb_cancel) begin
      bt_repair      = wb_next;
      pr_repair      = wb_next;
      pr_repair_last = wb_last_next;
    end else if (br_cancel) begin
      bt_repair = br_next;
    end
  end

  jhr_stage #(.TGT_BITS(TGT_BITS), .HW(HW), .HAS_LAST(1'b0)) u_bt (
    .clock     (clock),
    .reset     (reset),
    .load      (any_cancel),
    .load_hist (bt_repair),
    .load_last (30'd0),
    .jrop      (push),
    .target    (bt_target),
    .hist      (hr_path_bt),
    .last      (unused_bt_last),
    .hist_next (unused_bt_next),
    .last_next (unused_bt_last_next)
  );

  jhr_stage #(.TGT_BITS(TGT_BITS), .HW(HW), .HAS_LAST(1'b1)) u_pr (
    .clock     (clock),
    .reset     (reset),
    .load      (wb_cancel || br_cancel),
    .load_hist (pr_repair),
    .load_last (pr_repair_last),
    .jrop      (pr_jrop),
    .target    (pr_target),
    .hist      (unused_pr_hist),
    .last      (hr_last_pr),
    .hist_next (pr_next),
    .last_next (unused_pr_last_next)
  );

  jhr_stage #(.TGT_BITS(TGT_BITS), .HW(HW), .HAS_LAST(1'b1)) u_br (
    .clock     (clock),
    .reset     (reset),
    .load      (wb_cancel),
    .load_hist (wb_next),
    .load_last (wb_last_next),
    .jrop      (br_jrop),
    .target    (br_target),
    .hist      (hr_path_br),
    .last      (hr_last_br),
    .hist_next (br_next),
    .last_next (br_last_next)
  );

  jhr_stage #(.TGT_BITS(TGT_BITS), .HW(HW), .HAS_LAST(1'b1)) u_wb (
    .clock     (clock),
    .reset     (reset),
    .load      (1'b0),
    .load_hist ('0),
    .load_last (30'd0),
    .jrop      (wb_jrop),
    .target    (wb_target),
    .hist      (unused_wb_hist),
    .last      (unused_wb_last),
    .hist_next (wb_next),
    .last_next (wb_last_next)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hr_spec_cnt <= '0;
    end else if (any_cancel) begin
      hr_spec_cnt <= '0;
    end else if (push && !pr_jrop && (hr_spec_cnt != SW'(MAX_SPEC))) begin
      hr_spec_cnt <= hr_spec_cnt + 1'b1;
    end else if (pr_jrop && !push && (hr_spec_cnt != '0)) begin
      hr_spec_cnt <= hr_spec_cnt - 1'b1;
    end
  end

  logic [MaxHw-1:0] fold_wide;
  logic             unused_fold_hi;

  always_comb fold_wide = fold_hist(MaxHw'(hr_path_bt), HW, FOLD_W);

  assign hr_fold_bt     = fold_wide[FOLD_W-1:0];
  assign unused_fold_hi = ^fold_wide[MaxHw-1:FOLD_W];

endmodule

// File: tb/tb_gs232c_jhr_ckpt.sv
// Randomised self-checking bench for gs232c_jhr_ckpt against a behavioural history model.
module tb_gs232c_jhr_ckpt;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        pc_go, bt_jrop, pr_cancel, pr_jrop, br_cancel, br_jrop, wb_cancel, wb_jrop;
  logic [31:0] bt_target, pr_target, br_target, wb_target;
  logic [63:0] hr_path_bt, hr_path_br;
  logic [9:0]  hr_fold_bt;
  logic [29:0] hr_last_pr, hr_last_br;
  logic [2:0]  hr_spec_cnt;

  int total = 0;
  int bad   = 0;

  // Reference state
  logic [63:0] m_bt, m_pr, m_br, m_wb;
  logic [29:0] m_lpr, m_lbr, m_lwb;
  int          m_cnt;

  gs232c_jhr_ckpt #(.TGT_BITS(8), .HIST_N(8), .FOLD_W(10), .MAX_SPEC(7)) dut (
    .clock       (clock),
    .reset       (reset),
    .pc_go       (pc_go),
    .bt_jrop     (bt_jrop),
    .bt_target   (bt_target),
    .pr_cancel   (pr_cancel),
    .pr_jrop     (pr_jrop),
    .pr_target   (pr_target),
    .br_cancel   (br_cancel),
    .br_jrop     (br_jrop),
    .br_target   (br_target),
    .wb_cancel   (wb_cancel),
    .wb_jrop     (wb_jrop),
    .wb_target   (wb_target),
    .hr_path_bt  (hr_path_bt),
    .hr_path_br  (hr_path_br),
    .hr_fold_bt  (hr_fold_bt),
    .hr_last_pr  (hr_last_pr),
    .hr_last_br  (hr_last_br),
    .hr_spec_cnt (hr_spec_cnt)
  );

  always #5 clock = ~clock;

  function automatic logic [63:0] sh(input logic [63:0] h, input logic [31:0] t);
    return (h << 8) | 64'((t >> 2) & 32'hff);
  endfunction

  function automatic logic [9:0] mfold(input logic [63:0] h);
    logic [63:0] f;
    f = '0;
    for (int c = 0; c < 64; c += 10) f = f ^ ((h >> c) & 64'h3ff);
    return f[9:0];
  endfunction

  task automatic model_reset();
    m_bt = '0; m_pr = '0; m_br = '0; m_wb = '0;
    m_lpr = '0; m_lbr = '0; m_lwb = '0; m_cnt = 0;
  endtask

  task automatic model_step();
    logic [63:0] pn, bn, wn;
    logic [29:0] lpn, lbn, lwn;
    logic        push;
    if (reset) begin
      model_reset();
      return;
    end
    push = bt_jrop && pc_go;
    pn  = pr_jrop ? sh(m_pr, pr_target) : m_pr;
    bn  = br_jrop ? sh(m_br, br_target) : m_br;
    wn  = wb_jrop ? sh(m_wb, wb_target) : m_wb;
    lpn = pr_jrop ? pr_target[31:2] : m_lpr;
    lbn = br_jrop ? br_target[31:2] : m_lbr;
    lwn = wb_jrop ? wb_target[31:2] : m_lwb;
    // Every stage advances on its own, then the oldest cancel overwrites younger stages.
    m_pr = pn; m_br = bn; m_wb = wn; m_lpr = lpn; m_lbr = lbn; m_lwb = lwn;
    m_bt = push ? sh(m_bt, bt_target) : m_bt;
    if (wb_cancel) begin
      m_bt = wn; m_pr = wn; m_br = wn; m_lpr = lwn; m_lbr = lwn;
    end else if (br_cancel) begin
      m_bt = bn; m_pr = bn; m_lpr = lbn;
    end else if (pr_cancel) begin
      m_bt = pn;
    end
    if (wb_cancel || br_cancel || pr_cancel) m_cnt = 0;
    else if (push && !pr_jrop) m_cnt = (m_cnt < 7) ? m_cnt + 1 : 7;
    else if (pr_jrop && !push) m_cnt = (m_cnt > 0) ? m_cnt - 1 : 0;
  endtask

  task automatic clear_inputs();
    pc_go = 0; bt_jrop = 0; pr_cancel = 0; pr_jrop = 0; br_cancel = 0; br_jrop = 0;
    wb_cancel = 0; wb_jrop = 0;
    bt_target = '0; pr_target = '0; br_target = '0; wb_target = '0;
  endtask

  task automatic cycle();
    @(posedge clock);
    model_step();
    #1;
    clear_inputs();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (hr_path_bt !== 64'd0 || hr_path_br !== 64'd0 || hr_fold_bt !== 10'd0 ||
        hr_last_pr !== 30'd0 || hr_last_br !== 30'd0 || hr_spec_cnt !== 3'd0) begin
      bad++;
      $display("FAIL reset_state: bt=%h br=%h fold=%h lpr=%h lbr=%h cnt=%0d, all must be 0",
               hr_path_bt, hr_path_br, hr_fold_bt, hr_last_pr, hr_last_br, hr_spec_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      pc_go = 1; bt_jrop = 1; bt_target = $urandom;
      cycle();
    end
    total++;
    if (hr_path_bt !== m_bt || hr_spec_cnt !== 3'(m_cnt)) begin
      bad++;
      $display("FAIL pre_reset_push: bt=%h cnt=%0d, want bt=%h cnt=%0d",
               hr_path_bt, hr_spec_cnt, m_bt, m_cnt);
    end
    pc_go = 1; bt_jrop = 1; bt_target = $urandom;
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (hr_path_bt !== 64'd0 || hr_spec_cnt !== 3'd0) begin
      bad++;
      $display("FAIL async_reset: bt=%h cnt=%0d, want 0 0 before any edge",
               hr_path_bt, hr_spec_cnt);
    end
    cycle();
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_push_fold();
    do_reset();
    pc_go = 1; bt_jrop = 1; bt_target = 32'h0000_0404;
    cycle();
    pc_go = 1; bt_jrop = 1; bt_target = 32'h0000_0808;
    cycle();
    total++;
    if (hr_path_bt !== 64'h0102 || hr_path_bt !== m_bt) begin
      bad++;
      $display("FAIL push_path: got %h want %h", hr_path_bt, m_bt);
    end
    total++;
    if (hr_fold_bt !== 10'h102 || hr_fold_bt !== mfold(m_bt)) begin
      bad++;
      $display("FAIL push_fold: got %h want %h", hr_fold_bt, mfold(m_bt));
    end
    total++;
    if (hr_spec_cnt !== 3'd2) begin
      bad++;
      $display("FAIL push_cnt: got %0d want 2", hr_spec_cnt);
    end
    // pc_go low: no push
    bt_jrop = 1; bt_target = 32'hffff_fffc;
    cycle();
    total++;
    if (hr_path_bt !== m_bt || hr_spec_cnt !== 3'(m_cnt)) begin
      bad++;
      $display("FAIL push_gated: bt=%h cnt=%0d want bt=%h cnt=%0d",
               hr_path_bt, hr_spec_cnt, m_bt, m_cnt);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      pc_go = 1; bt_jrop = 1; bt_target = $urandom;
      cycle();
    end
    total++;
    if (hr_spec_cnt !== 3'd7) begin
      bad++;
      $display("FAIL spec_saturate: got %0d want 7", hr_spec_cnt);
    end
    total++;
    if (hr_path_bt !== m_bt || hr_fold_bt !== mfold(m_bt)) begin
      bad++;
      $display("FAIL hist_window: bt=%h fold=%h want bt=%h fold=%h",
               hr_path_bt, hr_fold_bt, m_bt, mfold(m_bt));
    end
    // Drain with confirms past zero.
    for (int i = 0; i < 9; i++) begin
      pr_jrop = 1; pr_target = $urandom;
      cycle();
    end
    total++;
    if (hr_spec_cnt !== 3'd0) begin
      bad++;
      $display("FAIL spec_floor: got %0d want 0", hr_spec_cnt);
    end
  endtask

  task automatic test_pr_cancel();
    logic [63:0] exp_bt;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      pr_jrop = 1; pr_target = $urandom;
      pc_go = 1; bt_jrop = 1; bt_target = $urandom;
      cycle();
    end
    pc_go = 1; bt_jrop = 1; bt_target = $urandom;
    cycle();
    exp_bt = sh(m_pr, 32'h0c);
    pr_cancel = 1; pr_jrop = 1; pr_target = 32'h0000_000c;
    pc_go = 1; bt_jrop = 1; bt_target = $urandom;
    cycle();
    total++;
    if (hr_path_bt !== exp_bt || hr_path_bt !== m_bt) begin
      bad++;
      $display("FAIL pr_cancel_path: got %h want %h", hr_path_bt, exp_bt);
    end
    total++;
    if (hr_last_pr !== 30'h3 || hr_spec_cnt !== 3'd0) begin
      bad++;
      $display("FAIL pr_cancel_last_cnt: lpr=%h cnt=%0d want 3 0", hr_last_pr, hr_spec_cnt);
    end
  endtask

  task automatic test_sim_cancel();
    logic [63:0] exp_h;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      br_jrop = 1; br_target = $urandom;
      pr_jrop = 1; pr_target = $urandom;
      cycle();
    end
    exp_h = sh(m_br, 32'h40);
    br_cancel = 1; pr_cancel = 1; br_jrop = 1; br_target = 32'h0000_0040;
    pr_jrop = 1; pr_target = $urandom;
    cycle();
    total++;
    if (hr_path_bt !== exp_h || hr_path_br !== exp_h) begin
      bad++;
      $display("FAIL dual_cancel_path: bt=%h br=%h want %h", hr_path_bt, hr_path_br, exp_h);
    end
    total++;
    if (hr_last_pr !== 30'h10 || hr_last_br !== 30'h10) begin
      bad++;
      $display("FAIL dual_cancel_last: lpr=%h lbr=%h want 10 10", hr_last_pr, hr_last_br);
    end
    // Expose pr history through a plain pr_cancel.
    pr_cancel = 1;
    cycle();
    total++;
    if (hr_path_bt !== exp_h) begin
      bad++;
      $display("FAIL dual_cancel_pr: got %h want %h", hr_path_bt, exp_h);
    end
  endtask

  task automatic test_wb_cancel();
    logic [63:0] exp_h;
    logic [29:0] exp_l;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      wb_jrop = 1; wb_target = $urandom;
      br_jrop = 1; br_target = $urandom;
      cycle();
    end
    exp_h = m_wb;
    exp_l = m_lwb;
    wb_cancel = 1; br_cancel = 1; br_jrop = 1; br_target = $urandom;
    pc_go = 1; bt_jrop = 1; bt_target = $urandom;
    cycle();
    total++;
    if (hr_path_bt !== exp_h || hr_path_br !== exp_h) begin
      bad++;
      $display("FAIL wb_cancel_path: bt=%h br=%h want %h", hr_path_bt, hr_path_br, exp_h);
    end
    total++;
    if (hr_last_br !== exp_l || hr_last_pr !== exp_l || hr_spec_cnt !== 3'd0) begin
      bad++;
      $display("FAIL wb_cancel_last: lbr=%h lpr=%h cnt=%0d want %h %h 0",
               hr_last_br, hr_last_pr, hr_spec_cnt, exp_l, exp_l);
    end
    pr_cancel = 1;
    cycle();
    total++;
    if (hr_path_bt !== exp_h) begin
      bad++;
      $display("FAIL wb_cancel_pr: got %h want %h", hr_path_bt, exp_h);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      pc_go     = ($urandom_range(0, 3) != 0);
      bt_jrop   = $urandom_range(0, 1) == 1;
      pr_jrop   = $urandom_range(0, 2) == 0;
      br_jrop   = $urandom_range(0, 2) == 0;
      wb_jrop   = $urandom_range(0, 2) == 0;
      pr_cancel = $urandom_range(0, 7) == 0;
      br_cancel = $urandom_range(0, 11) == 0;
      wb_cancel = $urandom_range(0, 15) == 0;
      bt_target = $urandom; pr_target = $urandom;
      br_target = $urandom; wb_target = $urandom;
      cycle();
      total++;
      if (hr_path_bt !== m_bt || hr_path_br !== m_br || hr_fold_bt !== mfold(m_bt) ||
          hr_last_pr !== m_lpr || hr_last_br !== m_lbr || hr_spec_cnt !== 3'(m_cnt)) begin
        bad++;
        $display("FAIL random[%0d]: bt=%h br=%h fold=%h lpr=%h lbr=%h cnt=%0d want %h %h %h %h %h %0d",
                 i, hr_path_bt, hr_path_br, hr_fold_bt, hr_last_pr, hr_last_br, hr_spec_cnt,
                 m_bt, m_br, mfold(m_bt), m_lpr, m_lbr, m_cnt);
      end
    end
  endtask

  initial begin
    clear_inputs();
    model_reset();
    test_reset();
    test_push_fold();
    test_saturate();
    test_pr_cancel();
    test_sim_cancel();
    test_wb_cancel();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
